nios_cpu_debug_ocimem_engine: RTL and testbench

- System-clock-side consumer of the debug slave's decoded JTAG commands: jdo plus the take_action_ocimem_* / take_no_action_ocimem_a strobes.
- Executes single-word reads and writes to the on-chip debug memory (OCI RAM) over an Avalon-MM-style master port.
- Returns results upstream on MonDReg, monitor_ready and monitor_error, which feed straight back into the debug slave wrapper.
- One clock domain; strobes arrive already synchronised to clk.

---
 rtl/nios_cpu_debug_ocimem_engine.sv | 188 ++++++++++++++++++
 tb/tb_nios_cpu_debug_ocimem_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_debug_ocimem_engine.sv
// OCI memory engine: executes the single-word debug read/write commands decoded
// by the JTAG debug slave against the on-chip debug RAM over an Avalon-MM style
// master port, and reports the result back on MonDReg / monitor_ready /
// monitor_error.
module nios_cpu_debug_ocimem_engine #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  // The stall counter starts at 0 on the first cycle of a state, so the
  // abort fires on the TIMEOUT-th stalled cycle.
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [31:0]     ABORT_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] addr;

  logic cmd_addr;
  logic cmd_rdnext;
  logic cmd_write;
  logic any_strobe;
  logic drop_idle;
  logic to_expired;

  // jdo[37] and jdo[2:0] carry nothing this engine consumes.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

  // Word address wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] to_next(input logic [TO_W-1:0] c);
    return c + TO_W'(1);
  endfunction

  assign mem_address = addr;

  // Command decode and priority: ADDR beats READ-NEXT beats WRITE; any
  // command losing arbitration in IDLE counts as a dropped command.
  always_comb begin
    cmd_addr   = take_action_ocimem_a;
    cmd_rdnext = take_no_action_ocimem_a & jdo[35];
    cmd_write  = take_action_ocimem_b;
    any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    drop_idle  = (cmd_addr & (cmd_rdnext | cmd_write)) | (cmd_rdnext & cmd_write);
    to_expired = (to_cnt == TO_LAST);
  end

  // Access FSM with registered bus requests, result register and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      to_cnt        <= '0;
      addr          <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Ready rises one cycle after returning to IDLE, so MonDReg is
          // already settled when the debug slave sees it.
          monitor_ready <= 1'b1;
          if (cmd_addr) begin
            addr <= jdo[ADDR_W+16:17];
            if (jdo[36]) begin
              monitor_error <= 1'b0;
            end
            if (jdo[35]) begin
              state         <= RD_REQ;
              mem_read      <= 1'b1;
              monitor_ready <= 1'b0;
              to_cnt        <= '0;
            end
          end else if (cmd_rdnext) begin
            addr          <= addr_next(addr);
            state         <= RD_REQ;
            mem_read      <= 1'b1;
            monitor_ready <= 1'b0;
            to_cnt        <= '0;
          end else if (cmd_write) begin
            mem_writedata <= jdo[34:3];
            MonDReg       <= jdo[34:3];
            state         <= WR_REQ;
            mem_write     <= 1'b1;
            monitor_ready <= 1'b0;
            to_cnt        <= '0;
          end
          // Placed after the clear so a dropped command still flags an error.
          if (drop_idle) begin
            monitor_error <= 1'b1;
          end
        end

        RD_REQ: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            to_cnt   <= '0;
            if (mem_readdatavalid) begin
              MonDReg <= mem_readdata;
              state   <= IDLE;
            end else begin
              state <= RD_WAIT;
            end
          end else if (to_expired) begin
            mem_read      <= 1'b0;
            monitor_error <= 1'b1;
            MonDReg       <= ABORT_WORD;
            state         <= IDLE;
          end else begin
            to_cnt <= to_next(to_cnt);
          end
        end

        RD_WAIT: begin
          if (mem_readdatavalid) begin
            MonDReg <= mem_readdata;
            state   <= IDLE;
          end else if (to_expired) begin
            monitor_error <= 1'b1;
            MonDReg       <= ABORT_WORD;
            state         <= IDLE;
          end else begin
            to_cnt <= to_next(to_cnt);
          end
        end

        WR_REQ: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            addr      <= addr_next(addr);
            state     <= IDLE;
          end else if (to_expired) begin
            mem_write     <= 1'b0;
            monitor_error <= 1'b1;
            MonDReg       <= ABORT_WORD;
            state         <= IDLE;
          end else begin
            to_cnt <= to_next(to_cnt);
          end
        end

        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase

      // Commands arriving while an access is in flight are lost.
      if ((state != IDLE) && any_strobe) begin
        monitor_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios_cpu_debug_ocimem_engine.sv
// Bench for the OCI memory engine: a memory slave with programmable stalls and
// read latency, and a transaction-level reference model of the debug commands.
module tb_nios_cpu_debug_ocimem_engine;

  localparam int ADDR_W     = 8;
  localparam int TIMEOUT    = 255;
  localparam int TO_W       = 8;
  localparam int WAIT_LIMIT = 600;
  localparam int FOREVER    = 100000;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;
  logic              mem_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  always #5 clk = ~clk;

  nios_cpu_debug_ocimem_engine #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .mem_address            (mem_address),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .mem_writedata          (mem_writedata),
    .mem_readdata           (mem_readdata),
    .mem_readdatavalid      (mem_readdatavalid),
    .mem_waitrequest        (mem_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave-side memory and the model's own copy of what memory should hold.
  logic [31:0] slv_mem [256];
  logic [31:0] ref_mem [256];

  // Slave behaviour for the current transaction.
  int          stall_left;
  int          lat_cfg;
  int          rdv_cnt;
  logic [31:0] rdv_data;

  // Observations collected by the slave.
  int          acc_n;
  int          acc_kind;
  logic [7:0]  acc_addr;
  logic [31:0] acc_data;
  int          req_cycles;
  int          wd_bad;
  logic [31:0] wd_exp;

  // Reference model state.
  logic [7:0]  m_addr;
  logic [31:0] m_mondreg;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_eval();
    mem_readdatavalid = 1'b0;
    mem_readdata      = $urandom;
    mem_waitrequest   = 1'b0;
    if (rdv_cnt > 0) begin
      rdv_cnt--;
      if (rdv_cnt == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = rdv_data;
      end
    end
    if (mem_read || mem_write) begin
      req_cycles++;
      if (mem_write && (mem_writedata !== wd_exp)) wd_bad++;
      if (stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        acc_n++;
        acc_addr = mem_address;
        acc_kind = mem_write ? 2 : 1;
        acc_data = mem_writedata;
        if (mem_write) begin
          slv_mem[mem_address] = mem_writedata;
        end else if (lat_cfg == 0) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = slv_mem[mem_address];
        end else begin
          rdv_cnt  = lat_cfg;
          rdv_data = slv_mem[mem_address];
        end
      end
    end
  endtask

  // One clock: strobes are single-cycle, outputs sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    slave_eval();
  endtask

  // kind: 0 ADDR, 1 READ-NEXT, 2 READ-NEXT with jdo[35]=0, 3 WRITE.
  task automatic do_txn(input string name, input int kind, input logic [7:0] a,
                        input logic rd, input logic clr, input logic [31:0] d,
                        input int stall, input int lat, input int inject_at,
                        input logic also_write);
    int          access;
    logic [7:0]  exp_acc_addr;
    logic        timed_out;
    int          exp_low;
    int          exp_req;
    int          low;

    access = 0;
    if (kind == 0) begin
      m_addr = a;
      if (clr) m_err = 1'b0;
      if (also_write) m_err = 1'b1;
      if (rd) access = 1;
    end else if (kind == 1) begin
      m_addr = m_addr + 8'd1;
      access = 1;
    end else if (kind == 3) begin
      m_mondreg = d;
      access = 2;
    end
    if (inject_at >= 0) m_err = 1'b1;
    exp_acc_addr = m_addr;
    timed_out = (access != 0) && ((stall >= TIMEOUT) || (access == 1 && lat > TIMEOUT));
    if (timed_out) begin
      m_err     = 1'b1;
      m_mondreg = 32'hDEAD_BEEF;
    end else if (access == 1) begin
      m_mondreg = ref_mem[m_addr];
    end else if (access == 2) begin
      ref_mem[m_addr] = d;
      m_addr = m_addr + 8'd1;
    end
    if (access == 0)      exp_low = 0;
    else if (timed_out)   exp_low = TIMEOUT + 1;
    else if (access == 1) exp_low = stall + lat + 2;
    else                  exp_low = stall + 2;
    exp_req = (access == 0) ? 0 : (timed_out ? TIMEOUT : stall + 1);

    acc_n = 0; acc_kind = 0; req_cycles = 0; wd_bad = 0; wd_exp = d;
    stall_left = stall; lat_cfg = lat; rdv_cnt = 0;

    jdo = {6'($urandom), $urandom};
    if (kind == 0) begin
      jdo[24:17] = a;
      jdo[35]    = rd;
      jdo[36]    = clr;
      take_action_ocimem_a = 1'b1;
      take_action_ocimem_b = also_write;
    end else if (kind == 1) begin
      jdo[35] = 1'b1;
      take_no_action_ocimem_a = 1'b1;
    end else if (kind == 2) begin
      jdo[35] = 1'b0;
      take_no_action_ocimem_a = 1'b1;
    end else begin
      jdo[34:3] = d;
      take_action_ocimem_b = 1'b1;
    end
    cycle();
    low = 0;
    while (monitor_ready !== 1'b1 && low < WAIT_LIMIT) begin
      low++;
      if (low == inject_at) take_action_ocimem_b = 1'b1;
      cycle();
    end

    chk({name, "_ready_low"}, low, exp_low);
    chk({name, "_accepts"}, acc_n, (access != 0 && !timed_out) ? 1 : 0);
    chk({name, "_req_cycles"}, req_cycles, exp_req);
    if (access != 0 && !timed_out) begin
      chk({name, "_acc_kind"}, acc_kind, access);
      chk({name, "_acc_addr"}, acc_addr, exp_acc_addr);
    end
    if (access == 2) begin
      chk({name, "_acc_data"}, acc_data, d);
      chk({name, "_wdata_stable"}, wd_bad, 0);
    end
    chk({name, "_MonDReg"}, MonDReg, m_mondreg);
    chk({name, "_error"}, monitor_error, m_err);
    chk({name, "_address"}, mem_address, m_addr);
  endtask

  task automatic chk_reset_values(input string name);
    chk({name, "_MonDReg"}, MonDReg, 32'h0);
    chk({name, "_ready"}, monitor_ready, 1);
    chk({name, "_error"}, monitor_error, 0);
    chk({name, "_read"}, mem_read, 0);
    chk({name, "_write"}, mem_write, 0);
    chk({name, "_address"}, mem_address, 0);
    chk({name, "_wdata"}, mem_writedata, 0);
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    mem_readdata = '0;
    mem_readdatavalid = 1'b0;
    mem_waitrequest = 1'b0;
    stall_left = 0; lat_cfg = 0; rdv_cnt = 0; rdv_data = '0;
    acc_n = 0; acc_kind = 0; acc_addr = '0; acc_data = '0;
    req_cycles = 0; wd_bad = 0; wd_exp = '0;
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    slv_mem[8'h10] = 32'h1234_5678;
    ref_mem[8'h10] = 32'h1234_5678;
    m_addr = '0; m_mondreg = '0; m_err = 1'b0;

    // Power-on reset.
    for (int i = 0; i < 3; i++) cycle();
    chk_reset_values("por");
    reset = 1'b0;
    cycle();

    // Basic read, zero wait states, data one cycle after accept.
    do_txn("rd10", 0, 8'h10, 1'b1, 1'b0, 32'h0, 0, 1, -1, 1'b0);

    // Write at the top word, wrap, then read-next.
    do_txn("addrFF", 0, 8'hFF, 1'b0, 1'b0, 32'h0, 0, 0, -1, 1'b0);
    do_txn("wrFF", 3, 8'h00, 1'b0, 1'b0, 32'hCAFE_F00D, 0, 0, -1, 1'b0);
    do_txn("rdnext01", 1, 8'h00, 1'b0, 1'b0, 32'h0, 0, 1, -1, 1'b0);

    // Write stalled for 4 cycles.
    do_txn("wrstall", 3, 8'h00, 1'b0, 1'b0, $urandom, 4, 0, -1, 1'b0);

    // Read stalled forever: abort, then clear, then abort again under a clearing ADDR.
    do_txn("rdabort", 0, 8'h55, 1'b1, 1'b0, 32'h0, FOREVER, 1, -1, 1'b0);
    do_txn("clrerr", 0, 8'h56, 1'b0, 1'b1, 32'h0, 0, 0, -1, 1'b0);
    do_txn("clrabort", 0, 8'h57, 1'b1, 1'b1, 32'h0, FOREVER, 1, -1, 1'b0);
    do_txn("clrerr2", 0, 8'h30, 1'b0, 1'b1, 32'h0, 0, 0, -1, 1'b0);

    // Write strobe while a read is in flight.
    do_txn("overrun", 0, 8'h31, 1'b1, 1'b0, 32'h0, 3, 2, 1, 1'b0);
    do_txn("clrerr3", 0, 8'h32, 1'b0, 1'b1, 32'h0, 0, 0, -1, 1'b0);

    // ADDR and WRITE in the same cycle: ADDR wins, error set.
    do_txn("addrwr", 0, 8'h40, 1'b0, 1'b0, 32'h0, 0, 0, -1, 1'b1);

    // Read with data in the accept cycle.
    do_txn("rdsame", 0, 8'h41, 1'b1, 1'b1, 32'h0, 2, 0, -1, 1'b0);

    // Randomised command mix.
    for (int t = 0; t < 40; t++) begin
      int          k;
      logic [7:0]  ra;
      logic [31:0] rd_word;
      k       = $urandom_range(0, 3);
      ra      = 8'($urandom);
      rd_word = $urandom;
      do_txn($sformatf("rnd%0d", t), k, ra, 1'($urandom), 1'($urandom), rd_word,
             $urandom_range(0, 3), $urandom_range(0, 3), -1, 1'b0);
    end

    // Reset while waiting for read data; the late data must be ignored.
    acc_n = 0; req_cycles = 0; stall_left = 0; lat_cfg = 5; rdv_cnt = 0;
    jdo = '0;
    jdo[24:17] = 8'h20;
    jdo[35]    = 1'b1;
    take_action_ocimem_a = 1'b1;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk_reset_values("rstwait");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    chk("rstlate_MonDReg", MonDReg, 32'h0);
    chk("rstlate_ready", monitor_ready, 1);
    chk("rstlate_error", monitor_error, 0);
    chk("rstlate_req_cycles", req_cycles, 1);
    chk("rstlate_accepts", acc_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
